// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-master arbiter and access sequencer for a shared async SRAM
module sram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic last_grant, gnt, is_write, pick, start;
  logic [3:0] cnt;
  assign start  = state == IDLE && (cpu_req || dma_req);
  assign pick   = (cpu_req && dma_req) ? ~last_grant : dma_req;
  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;
  // state register; reset aborts any access in flight
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : state_nxt;
  // next state and strobes; DQ keeps driving through DONE so write data outlasts WE
  always_comb begin
    state_nxt  = state;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    sram_dq_oe = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    if (start) state_nxt = ACCESS;
    if (state == ACCESS) begin
      Mem_OE     = is_write;
      Mem_WE     = ~is_write;
      sram_dq_oe = is_write;
      state_nxt  = (cnt == '0) ? DONE : ACCESS;
    end
    if (state == DONE) begin
      sram_dq_oe = is_write;
      cpu_ack    = ~gnt;
      dma_ack    = gnt;
      state_nxt  = IDLE;
    end
  end
  // grant latch, wait counter and read-data capture on the last ACCESS edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      is_write    <= 1'b0;
      cnt         <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
    end else if (start) begin
      gnt         <= pick;
      last_grant  <= pick;
      is_write    <= pick ? dma_we : cpu_we;
      sram_addr   <= pick ? dma_addr : cpu_addr;
      sram_dq_out <= pick ? dma_wdata : cpu_wdata;
      cnt         <= 4'(WAIT_CYC - 1);
    end else if (state == ACCESS) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0 && !is_write && gnt) dma_rdata <= sram_dq_in;
      if (cnt == '0 && !is_write && !gnt) cpu_rdata <= sram_dq_in;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: timeline reference model vs sram_arbiter, directed plan plus random traffic
module tb_sram_arbiter;
  localparam int W = 2;
  logic Clk = 1'b0, Reset = 1'b1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [19:0] cpu_addr = 0, dma_addr = 0, sram_addr;
  logic [15:0] cpu_wdata = 0, dma_wdata = 0, cpu_rdata, dma_rdata, sram_dq_out, sram_dq_in;
  logic cpu_ack, dma_ack, sram_dq_oe, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic s1_req = 0, s1_ack, s1_dack, s1_dq_oe, s1_ce, s1_ub, s1_lb, s1_oe, s1_we;
  logic [19:0] s1_addr = 0, s1_saddr;
  logic [15:0] s1_rdata, s1_drd, s1_dq_out, s1_dq_in;
  logic [15:0] mem [64];
  logic [15:0] ref_mem [64];
  int checks = 0, errors = 0;
  int e = 0, start = -100, p;
  bit active = 0, m_last = 1, m_gnt = 0, m_we = 0, c_ack = 0, d_ack = 0;
  logic [19:0] m_addr = 0;
  logic [15:0] m_dq = 0, m_rd [2];
  int lat, n_oe, n_we, n_dq, n_ack;
  int who [8];
  int tm [8];

  always #5 Clk = ~Clk;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(W)) u0 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE));

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(1)) u1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(s1_req), .cpu_we(1'b0), .cpu_addr(s1_addr), .cpu_wdata(16'h0),
    .cpu_rdata(s1_rdata), .cpu_ack(s1_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(20'h0), .dma_wdata(16'h0),
    .dma_rdata(s1_drd), .dma_ack(s1_dack),
    .sram_addr(s1_saddr), .sram_dq_out(s1_dq_out), .sram_dq_oe(s1_dq_oe),
    .sram_dq_in(s1_dq_in), .Mem_CE(s1_ce), .Mem_UB(s1_ub), .Mem_LB(s1_lb),
    .Mem_OE(s1_oe), .Mem_WE(s1_we));

  // asynchronous SRAM: reads are combinational, writes land while WE is low
  assign sram_dq_in = mem[sram_addr[5:0]];
  assign s1_dq_in   = s1_saddr[15:0] ^ 16'h5A5A;
  always @(negedge Clk) if (!Mem_WE) mem[sram_addr[5:0]] <= sram_dq_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    checks++;
    assert (obs === req_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, req_v);
    end
  endtask

  // one clock: advance the access timeline at posedge, compare every pin at negedge
  task automatic step();
    @(posedge Clk);
    e++;
    if (Reset) begin
      active = 0; m_last = 1; m_addr = 0; m_dq = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (active) begin
      if (e - start == W && !m_we) m_rd[m_gnt] = ref_mem[m_addr[5:0]];
      if (e - start == W + 1) active = 0;
    end else if (cpu_req || dma_req) begin
      m_gnt  = (cpu_req && dma_req) ? !m_last : dma_req;
      m_last = m_gnt;
      m_we   = m_gnt ? dma_we : cpu_we;
      m_addr = m_gnt ? dma_addr : cpu_addr;
      m_dq   = m_gnt ? dma_wdata : cpu_wdata;
      if (m_we) ref_mem[m_addr[5:0]] = m_dq;
      active = 1;
      start  = e;
    end
    @(negedge Clk);
    p = e - start;
    c_ack = active && p == W && !m_gnt;
    d_ack = active && p == W && m_gnt;
    chk("oe_n", Mem_OE, !(active && p < W && !m_we));
    chk("we_n", Mem_WE, !(active && p < W && m_we));
    chk("dq_oe", sram_dq_oe, active && p <= W && m_we);
    chk("cpu_ack", cpu_ack, c_ack);
    chk("dma_ack", dma_ack, d_ack);
    chk("cpu_rdata", cpu_rdata, m_rd[0]);
    chk("dma_rdata", dma_rdata, m_rd[1]);
    chk("sram_addr", sram_addr, m_addr);
    chk("dq_out", sram_dq_out, m_dq);
    chk("ce_ub_lb", {Mem_CE, Mem_UB, Mem_LB}, 3'b000);
  endtask

  // single directed access on one port, measuring pin activity up to its ack
  task automatic access(input bit d, input bit we, input logic [19:0] a, input logic [15:0] wd);
    lat = 0; n_oe = 0; n_we = 0; n_dq = 0;
    if (d) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = wd; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      step();
      n_oe += int'(!Mem_OE);
      n_we += int'(!Mem_WE);
      n_dq += int'(sram_dq_oe);
      if (d ? dma_ack : cpu_ack) lat = i;
    end
    cpu_req = 0;
    dma_req = 0;
  endtask

  // let outstanding requests finish, dropping each only once acknowledged
  task automatic drain();
    for (int i = 0; i < 12 && (cpu_req || dma_req); i++) begin
      step();
      if (c_ack) cpu_req = 0;
      if (d_ack) dma_req = 0;
    end
    chk("drain_timeout", {cpu_req, dma_req}, 2'b00);
  endtask

  task automatic new_req(input bit d);
    if (d) begin
      dma_req = $urandom_range(0, 3) != 0; dma_we = 1'($urandom_range(0, 1));
      dma_addr = 20'($urandom_range(0, 63)); dma_wdata = 16'($urandom);
    end else begin
      cpu_req = $urandom_range(0, 3) != 0; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 20'($urandom_range(0, 63)); cpu_wdata = 16'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [15:0] v;
      v = (i == 16) ? 16'hBEEF : 16'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    m_rd[0] = 0;
    m_rd[1] = 0;
    step();
    step();
    Reset = 0;
    step();
    // CPU read of 0x10
    access(0, 0, 20'h00010, 16'h0);
    chk("rd_lat", lat, W + 1);
    chk("rd_oe_cycles", n_oe, W);
    chk("rd_data", cpu_rdata, 16'hBEEF);
    chk("rd_dma_untouched", dma_rdata, 16'h0);
    step();
    // DMA write 0x1234 to 0x3F
    access(1, 1, 20'h0003F, 16'h1234);
    chk("wr_lat", lat, W + 1);
    chk("wr_we_cycles", n_we, W);
    chk("wr_dqoe_cycles", n_dq, W + 1);
    chk("wr_oe_cycles", n_oe, 0);
    step();
    chk("wr_mem", mem[63], 16'h1234);
    // simultaneous requests from reset, both re-requesting on ack
    Reset = 1;
    step();
    Reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'd5;
    dma_req = 1; dma_we = 0; dma_addr = 20'd9;
    n_ack = 0;
    for (int i = 1; i <= 4 * (W + 2) + 2; i++) begin
      step();
      if ((cpu_ack || dma_ack) && n_ack < 8) begin who[n_ack] = int'(dma_ack); tm[n_ack] = i; n_ack++; end
      if (c_ack) cpu_addr = 20'($urandom_range(0, 63));
      if (d_ack) dma_addr = 20'($urandom_range(0, 63));
    end
    drain();
    chk("rr_count", n_ack >= 4, 1);
    for (int k = 0; k < 4 && k < n_ack; k++) chk("rr_order", who[k], k % 2);
    for (int k = 1; k < 4 && k < n_ack; k++) chk("rr_spacing", tm[k] - tm[k-1], W + 2);
    // CPU held, DMA arrives mid-access
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'd16;
    n_ack = 0;
    for (int i = 1; i <= 3 * (W + 2); i++) begin
      step();
      if (i == 2) begin dma_req = 1; dma_we = 0; dma_addr = 20'd7; end
      if ((cpu_ack || dma_ack) && n_ack < 8) begin who[n_ack] = int'(dma_ack); n_ack++; end
      if (d_ack) dma_req = 0;
    end
    drain();
    chk("pend_count", n_ack >= 3, 1);
    for (int k = 0; k < 3 && k < n_ack; k++) chk("pend_order", who[k], k % 2);
    // reset during second ACCESS cycle of a write
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h20; cpu_wdata = 16'hCAFE;
    step();
    step();
    Reset = 1;
    cpu_req = 0;
    step();
    chk("rst_we", Mem_WE, 1);
    chk("rst_dqoe", sram_dq_oe, 0);
    chk("rst_ack", cpu_ack, 0);
    Reset = 0;
    step();
    access(0, 0, 20'h00010, 16'h0);
    chk("rst_rd_lat", lat, W + 1);
    chk("rst_rd_data", cpu_rdata, 16'hBEEF);
    // random traffic from both masters
    for (int i = 0; i < 500; i++) begin
      if (!cpu_req || c_ack) new_req(0);
      if (!dma_req || d_ack) new_req(1);
      step();
    end
    if (c_ack) cpu_req = 0;
    if (d_ack) dma_req = 0;
    drain();
    step();
    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);
    // WAIT_CYC = 1 instance
    s1_addr = 20'h00123;
    s1_req = 1;
    lat = 0; n_oe = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      n_oe += int'(!s1_oe);
      if (s1_ack && lat == 0) begin lat = i; s1_req = 0; end
    end
    chk("w1_lat", lat, 2);
    chk("w1_oe_cycles", n_oe, 1);
    chk("w1_rdata", s1_rdata, 16'h0123 ^ 16'h5A5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
